// File: rtl/direction_control.sv
// Snake player-input front end: synchronise, debounce and prioritise buttons, commit direction on frame_tick.
// Build macro DIR_REVERSE_BLOCK_EN: when defined, 180-degree reversal requests are rejected.
module direction_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18,
  parameter logic [1:0]  INIT_DIR        = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       frame_tick,
  output logic [0:1] direction,
  output logic       dir_changed
);

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_TOP   = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit index equals the direction code, so index order is also priority order.
  logic [3:0] btn_raw;
  logic [3:0] s1_q, s2_q;
  logic [3:0] stable_q, stable_d;
  logic [3:0] stable_prev_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0] press;

  dir_e direction_q, direction_d;
  dir_e pending_q, pending_d;
  logic pending_valid_q, pending_valid_d;
  logic dir_changed_q, dir_changed_d;

  dir_e req_dir, ref_dir;
  logic req_valid, commit, accept;

  assign btn_raw = {btn_down, btn_right, btn_up, btn_left};

  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press = stable_q & ~stable_prev_q;

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_LEFT;
    if (press[0])      req_dir = DIR_LEFT;
    else if (press[1]) req_dir = DIR_TOP;
    else if (press[2]) req_dir = DIR_RIGHT;
    else if (press[3]) req_dir = DIR_DOWN;
    else               req_valid = 1'b0;
  end

  // A request landing on a committing tick is judged against the direction being committed.
  assign commit  = frame_tick & pending_valid_q;
  assign ref_dir = commit ? pending_q : direction_q;

`ifdef DIR_REVERSE_BLOCK_EN
  assign accept = req_valid && ((req_dir ^ ref_dir) != 2'b00) && ((req_dir ^ ref_dir) != 2'b10);
`else
  assign accept = req_valid && ((req_dir ^ ref_dir) != 2'b00);
`endif

  always_comb begin
    direction_d     = commit ? pending_q : direction_q;
    dir_changed_d   = commit;
    pending_d       = accept ? req_dir : pending_q;
    pending_valid_d = accept | (pending_valid_q & ~frame_tick);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q          <= '0;
      s2_q          <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      s1_q          <= btn_raw;
      s2_q          <= s1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      direction_q     <= dir_e'(INIT_DIR);
      pending_q       <= dir_e'(INIT_DIR);
      pending_valid_q <= 1'b0;
      dir_changed_q   <= 1'b0;
    end else begin
      direction_q     <= direction_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      dir_changed_q   <= dir_changed_d;
    end
  end

  assign direction   = direction_q;
  assign dir_changed = dir_changed_q;

endmodule

// File: tb/tb_direction_control.sv
// Self-checking bench for direction_control with DEBOUNCE_CYCLES=4; expected commits are queued and popped on dir_changed.
module tb_direction_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btns = 4'b0000;   // [0]=left [1]=up [2]=right [3]=down
  logic       frame_tick = 1'b0;
  logic [0:1] direction;
  logic       dir_changed;

  int checks = 0;
  int passed = 0;
  logic [1:0] exp_q [$];

  direction_control #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4),
    .INIT_DIR(2'b10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_left(btns[0]),
    .btn_up(btns[1]),
    .btn_right(btns[2]),
    .btn_down(btns[3]),
    .frame_tick(frame_tick),
    .direction(direction),
    .dir_changed(dir_changed)
  );

  always #5 clk = ~clk;

  // Every dir_changed pulse must match the oldest queued expected direction.
  always @(negedge clk) begin
    if (!reset && dir_changed === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_unexpected_commit: direction=%b, no commit expected", direction);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (direction !== e) $display("FAIL scoreboard_commit: direction=%b expected %b", direction, e);
        else passed++;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    btns = 4'b0000;
    frame_tick = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic press_release(input int idx, input int hold);
    btns[idx] = 1'b1;
    repeat (hold) @(negedge clk);
    btns[idx] = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btns = 4'b0000;
    frame_tick = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (direction !== 2'b10) $display("FAIL reset_direction: got %b expected 10", direction);
    else passed++;
    checks++;
    if (dir_changed !== 1'b0) $display("FAIL reset_dir_changed: got %b expected 0", dir_changed);
    else passed++;
  endtask

  task automatic test_press_commit();
    reset = 1'b0;
    btns[1] = 1'b1;
    exp_q.push_back(2'b01);
    repeat (5) @(negedge clk);          // after edge 5
    frame_tick = 1'b1;                  // ticks on edges 6 and 7: nothing pending yet
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    checks++;
    if (direction !== 2'b10 || dir_changed !== 1'b0)
      $display("FAIL early_tick_no_commit: direction=%b dir_changed=%b expected 10/0", direction, dir_changed);
    else passed++;
    @(negedge clk);                     // after edge 8, no tick
    checks++;
    if (direction !== 2'b10) $display("FAIL hold_until_tick: got %b expected 10", direction);
    else passed++;
    tick();                             // edge 9 commits
    checks++;
    if (direction !== 2'b01 || dir_changed !== 1'b1)
      $display("FAIL up_commit: direction=%b dir_changed=%b expected 01/1", direction, dir_changed);
    else passed++;
    @(negedge clk);
    checks++;
    if (dir_changed !== 1'b0) $display("FAIL dir_changed_width: got %b expected 0", dir_changed);
    else passed++;
    btns[1] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reversal();
    do_reset();
`ifndef DIR_REVERSE_BLOCK_EN
    exp_q.push_back(2'b00);
`endif
    press_release(0, 8);
    tick();
`ifdef DIR_REVERSE_BLOCK_EN
    checks++;
    if (direction !== 2'b10 || dir_changed !== 1'b0)
      $display("FAIL reversal_blocked: direction=%b dir_changed=%b expected 10/0", direction, dir_changed);
    else passed++;
`else
    checks++;
    if (direction !== 2'b00 || dir_changed !== 1'b1)
      $display("FAIL reversal_allowed: direction=%b dir_changed=%b expected 00/1", direction, dir_changed);
    else passed++;
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_glitch();
    do_reset();
    btns[3] = 1'b1; repeat (3) @(negedge clk);
    btns[3] = 1'b0; repeat (2) @(negedge clk);
    btns[3] = 1'b1; repeat (3) @(negedge clk);
    btns[3] = 1'b0; repeat (8) @(negedge clk);
    tick();
    checks++;
    if (direction !== 2'b10 || dir_changed !== 1'b0)
      $display("FAIL glitch_rejected: direction=%b dir_changed=%b expected 10/0", direction, dir_changed);
    else passed++;
    exp_q.push_back(2'b11);
    press_release(3, 6);
    tick();
    checks++;
    if (direction !== 2'b11 || dir_changed !== 1'b1)
      $display("FAIL steady_hold_commit: direction=%b dir_changed=%b expected 11/1", direction, dir_changed);
    else passed++;
    repeat (2) @(negedge clk);
    tick();
    checks++;
    if (direction !== 2'b11 || dir_changed !== 1'b0)
      $display("FAIL single_event: direction=%b dir_changed=%b expected 11/0", direction, dir_changed);
    else passed++;
  endtask

  task automatic test_last_wins();
    do_reset();
    exp_q.push_back(2'b11);
    press_release(1, 8);
    press_release(3, 8);
    tick();
    checks++;
    if (direction !== 2'b11) $display("FAIL last_request_wins: got %b expected 11", direction);
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    // Starts from DOWN: LEFT and UP together, LEFT wins by priority.
    btns[0] = 1'b1; btns[1] = 1'b1;
    repeat (8) @(negedge clk);
    btns = 4'b0000;
    repeat (8) @(negedge clk);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b01);
    btns[1] = 1'b1;
    repeat (6) @(negedge clk);
    frame_tick = 1'b1;                  // tick coincides with the UP press event
    @(negedge clk);
    frame_tick = 1'b0;
    checks++;
    if (direction !== 2'b00 || dir_changed !== 1'b1)
      $display("FAIL priority_left_commit: direction=%b dir_changed=%b expected 00/1", direction, dir_changed);
    else passed++;
    btns[1] = 1'b0;
    repeat (8) @(negedge clk);
    tick();
    checks++;
    if (direction !== 2'b01 || dir_changed !== 1'b1)
      $display("FAIL same_cycle_request: direction=%b dir_changed=%b expected 01/1", direction, dir_changed);
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    press_release(2, 8);                // RIGHT pending, never committed
    btns[1] = 1'b1;
    repeat (4) @(negedge clk);          // UP counter mid-debounce
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if (direction !== 2'b10 || dir_changed !== 1'b0)
      $display("FAIL async_reset: direction=%b dir_changed=%b expected 10/0", direction, dir_changed);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if (direction !== 2'b10 || dir_changed !== 1'b0)
      $display("FAIL pending_cleared: direction=%b dir_changed=%b expected 10/0", direction, dir_changed);
    else passed++;
    exp_q.push_back(2'b01);             // UP held through reset release gives one fresh event
    repeat (8) @(negedge clk);
    tick();
    checks++;
    if (direction !== 2'b01 || dir_changed !== 1'b1)
      $display("FAIL held_through_reset: direction=%b dir_changed=%b expected 01/1", direction, dir_changed);
    else passed++;
    btns = 4'b0000;
    repeat (8) @(negedge clk);
    tick();
    checks++;
    if (direction !== 2'b01 || dir_changed !== 1'b0)
      $display("FAIL no_second_event: direction=%b dir_changed=%b expected 01/0", direction, dir_changed);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_press_commit();
    test_reversal();
    test_glitch();
    test_last_wins();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drained: %0d commits outstanding, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
